// File: rtl/pipelined_segmented_adder.sv
// Segment-per-stage ripple adder/subtractor with valid/ready handshake and global stall.
// Carries ripple one segment per cycle; skew/deskew registers keep each operation aligned.
module pipelined_segmented_adder #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SEG_WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   localparam int unsigned NSEG = WIDTH / SEG_WIDTH;

   // a/b hold operands not yet consumed (skew); s holds finished segments (deskew).
   logic [WIDTH-1:0] a_q [NSEG];
   logic [WIDTH-1:0] a_d [NSEG];
   logic [WIDTH-1:0] b_q [NSEG];
   logic [WIDTH-1:0] b_d [NSEG];
   logic [WIDTH-1:0] s_q [NSEG];
   logic [WIDTH-1:0] s_d [NSEG];
   logic [NSEG-1:0]  c_q, c_d;
   logic [NSEG-1:0]  v_q, v_d;
   logic             ovf_q, ovf_d;
   logic             stall;

   logic [WIDTH-1:0] in_a [NSEG];
   logic [WIDTH-1:0] in_b [NSEG];
   logic [WIDTH-1:0] in_s [NSEG];
   logic [NSEG-1:0]  in_c;
   logic [NSEG-1:0]  in_v;

   logic [SEG_WIDTH-1:0] seg_a, seg_b;
   logic [SEG_WIDTH:0]   seg_r;

   always_comb begin
      in_a[0] = din1;
      in_b[0] = sub ? ~din2 : din2;
      in_s[0] = '0;
      in_c[0] = sub ? 1'b1 : cin;
      in_v[0] = in_valid;
      for (int k = 1; k < NSEG; k++) begin
         in_a[k] = a_q[k-1];
         in_b[k] = b_q[k-1];
         in_s[k] = s_q[k-1];
         in_c[k] = c_q[k-1];
         in_v[k] = v_q[k-1];
      end
   end

   always_comb begin
      seg_a = '0;
      seg_b = '0;
      seg_r = '0;
      for (int k = 0; k < NSEG; k++) begin
         seg_a  = SEG_WIDTH'(in_a[k] >> (k * SEG_WIDTH));
         seg_b  = SEG_WIDTH'(in_b[k] >> (k * SEG_WIDTH));
         seg_r  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_WIDTH{1'b0}}, in_c[k]};
         a_d[k] = in_a[k];
         b_d[k] = in_b[k];
         s_d[k] = in_s[k] | (WIDTH'(seg_r[SEG_WIDTH-1:0]) << (k * SEG_WIDTH));
         c_d[k] = seg_r[SEG_WIDTH];
         v_d[k] = in_v[k];
      end
      // seg_* now belong to the top segment; carry into the MSB is a^b^sum at the MSB
      ovf_d = seg_r[SEG_WIDTH] ^ seg_a[SEG_WIDTH-1] ^ seg_b[SEG_WIDTH-1] ^ seg_r[SEG_WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q   <= '0;
         v_q   <= '0;
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < NSEG; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
         c_q   <= c_d;
         v_q   <= v_d;
         ovf_q <= ovf_d;
      end
   end

   assign stall     = v_q[NSEG-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = v_q[NSEG-1];
   assign sum       = s_q[NSEG-1];
   assign carry     = c_q[NSEG-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Bench for pipelined_segmented_adder: directed and random ops against an arithmetic model,
// with a queue tracking when each accepted result is due at the output.
module tb_pipelined_segmented_adder;

   localparam int unsigned WIDTH     = 32;
   localparam int unsigned SEG_WIDTH = 8;
   localparam int          NSEG      = 4;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, cin, sub, out_valid, out_ready, carry, ovf;
   logic [WIDTH-1:0]  din1, din2, sum;

   always #5 clk = ~clk;

   pipelined_segmented_adder #(
      .WIDTH    (WIDTH),
      .SEG_WIDTH(SEG_WIDTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .din1     (din1),
      .din2     (din2),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .carry    (carry),
      .ovf      (ovf)
   );

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
      int               due;
   } exp_t;

   exp_t q[$];
   int   n_chk   = 0;
   int   n_pass  = 0;
   int   step_no = 0;

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic ci, input logic s);
      exp_t        e;
      longint      sa, lmax, lmin;
      logic [63:0] ua;
      lmax = (longint'(1) <<< (WIDTH - 1)) - 1;
      lmin = -(longint'(1) <<< (WIDTH - 1));
      if (s) begin
         e.sum   = a - b;
         e.carry = (a >= b);
         sa      = longint'($signed(a)) - longint'($signed(b));
      end else begin
         ua      = {32'd0, a} + {32'd0, b} + {63'd0, ci};
         e.sum   = ua[31:0];
         e.carry = ua[32];
         sa      = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      end
      e.ovf = (sa > lmax) || (sa < lmin);
      e.due = 0;
      return e;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
   endtask

   // One cycle: drive at negedge, check outputs, update the model, cross the rising edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ci, input logic s, input logic ordy, input logic do_rst,
                       input logic use_x, input logic [WIDTH-1:0] xs, input logic xc,
                       input logic xo);
      exp_t e;
      logic exp_ov, exp_stall;
      rst       = do_rst;
      in_valid  = v;
      din1      = a;
      din2      = b;
      cin       = ci;
      sub       = s;
      out_ready = ordy;
      #1;
      if (do_rst) begin
         q.delete();
      end else begin
         exp_ov = (q.size() > 0) && (q[0].due == step_no);
         check("out_valid", 64'(out_valid), 64'(exp_ov));
         if (exp_ov) begin
            check("sum", 64'(sum), 64'(q[0].sum));
            check("carry", 64'(carry), 64'(q[0].carry));
            check("ovf", 64'(ovf), 64'(q[0].ovf));
         end
         exp_stall = exp_ov && !ordy;
         check("in_ready", 64'(in_ready), 64'(!exp_stall));
         if (exp_ov && ordy) void'(q.pop_front());
         if (exp_stall) foreach (q[i]) q[i].due++;
         if (v && !exp_stall) begin
            e = model(a, b, ci, s);
            if (use_x) begin
               e.sum   = xs;
               e.carry = xc;
               e.ovf   = xo;
            end
            e.due = step_no + NSEG;
            q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
      step_no++;
   endtask

   task automatic op_x(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                       input logic s, input logic [WIDTH-1:0] xs, input logic xc, input logic xo);
      step(1'b1, a, b, ci, s, 1'b1, 1'b0, 1'b1, xs, xc, xo);
   endtask

   task automatic op_rand(input logic v, input logic ordy);
      step(v, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ordy, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op_rand(1'b0, 1'b1);
   endtask

   task automatic reset_step();
      step(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_sum"}, 64'(sum), 64'(0));
      check({tag, "_carry"}, 64'(carry), 64'(0));
      check({tag, "_ovf"}, 64'(ovf), 64'(0));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; din1 = '0; din2 = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      reset_step();
      reset_step();
      check_cleared("reset");

      // Carry ripple through every stage, then the sub/add corner cases.
      op_x(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      idle(NSEG);
      op_x(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      op_x(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      op_x(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      op_x(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0);
      idle(NSEG);

      // Back-to-back random stream.
      for (int i = 0; i < 16; i++) op_rand(1'b1, 1'b1);
      idle(NSEG);

      // Full pipeline held by backpressure, then drained.
      for (int i = 0; i < 6; i++) op_rand(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) op_rand(1'b1, 1'b0);
      idle(2 * NSEG);

      // Same with bubbles interleaved and ragged backpressure.
      for (int i = 0; i < 10; i++) op_rand(1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 5; i++) op_rand(1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 20; i++) op_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(3 * NSEG);

      // Reset with operations in flight discards them.
      for (int i = 0; i < 3; i++) op_rand(1'b1, 1'b1);
      reset_step();
      check_cleared("midrst");
      idle(6);
      op_x(32'h1234_5678, 32'h0000_0008, 1'b0, 1'b1, 32'h1234_5670, 1'b1, 1'b0);
      idle(NSEG + 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
